// File: rtl/nibble_serial_sub_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub_ctrl_if
// Request/result bundle between a requester and the nibble-serial subtract
// sequencer.
//   start  request to begin a subtraction (honoured only while idle)
//   a, b   minuend / subtrahend, WIDTH bits
//   bin    borrow-in to the least significant nibble
//   ack    consumer acknowledge of a completed result
//   idle   sequencer can accept start
//   busy   subtraction in progress
//   done   result valid, held until ack
//   diff   a - b - bin modulo 2^WIDTH
//   bout   borrow out of the most significant nibble
//   ovf    two's-complement overflow
//   zero   diff is all zeros
// master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface nibble_serial_sub_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ack;
  logic             idle;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin, ack,
    input  idle, busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin, ack,
    output idle, busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub_ctrl
// Multi-word subtract sequencer: computes a - b - bin one nibble per clock,
// LSB nibble first, through a single 4-bit borrow-lookahead subtract stage.
// The inter-nibble borrow lives in a register. Start/done/ack handshake.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nibble_serial_sub_ctrl_if slave modport (see interface header)
// WIDTH must be a multiple of 4 and at least 4.
// -----------------------------------------------------------------------------
module nibble_serial_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_sub_ctrl_if.slave   bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_next;
  logic             borrow;
  logic             bout_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             last;

  logic [3:0]       x;
  logic [3:0]       y;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [3:0]       q;
  logic [3:0]       d;
  logic [4:0]       c;

  assign last = (cnt == CW'(NIB - 1));

  // Select the operand nibble addressed by the counter.
  always_comb begin
    x = '0;
    y = '0;
    for (int k = 0; k < NIB; k++) begin
      if (cnt == CW'(k)) begin
        x = a_reg[4*k +: 4];
        y = b_reg[4*k +: 4];
      end
    end
  end

  // 4-bit borrow-lookahead stage. q marks bits that pass an incoming borrow
  // through (x == y); g marks bits that generate one (x = 0, y = 1).
  assign p = x ^ y;
  assign g = ~x & y;
  assign q = ~p;

  assign c[0] = borrow;
  assign c[1] = g[0] | (q[0] & c[0]);
  assign c[2] = g[1] | (q[1] & g[0]) | (q[1] & q[0] & c[0]);
  assign c[3] = g[2] | (q[2] & g[1]) | (q[2] & q[1] & g[0])
              | (q[2] & q[1] & q[0] & c[0]);
  assign c[4] = g[3] | (q[3] & g[2]) | (q[3] & q[2] & g[1])
              | (q[3] & q[2] & q[1] & g[0])
              | (q[3] & q[2] & q[1] & q[0] & c[0]);
  assign d    = p ^ c[3:0];

  // Result word with the current nibble merged in; on the last nibble this
  // is the final difference, which feeds the ovf/zero flags directly.
  always_comb begin
    diff_next = diff_reg;
    for (int k = 0; k < NIB; k++) begin
      if (cnt == CW'(k)) begin
        diff_next[4*k +: 4] = d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start is only looked at in IDLE and ack only in DONE, so a simultaneous
  // start+ack in DONE just returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (bus.ack)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Operand capture, nibble sweep and result flags. Results persist through
  // DONE and IDLE until the next accepted start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      borrow   <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      bout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            borrow   <= bus.bin;
            diff_reg <= '0;
            bout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
            cnt      <= '0;
          end
        end
        RUN: begin
          diff_reg <= diff_next;
          borrow   <= c[4];
          cnt      <= cnt + 1'b1;
          if (last) begin
            cnt      <= '0;
            bout_reg <= c[4];
            ovf_reg  <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])
                      & (diff_next[WIDTH-1] ^ a_reg[WIDTH-1]);
            zero_reg <= ~|diff_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.idle = (state == IDLE);
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.zero = zero_reg;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_sub_ctrl
// Self-checking bench for nibble_serial_sub_ctrl (WIDTH = 16): directed
// vector table, handshake corner cases, asynchronous reset mid-operation and
// randomized operations checked against an integer-arithmetic reference.
// -----------------------------------------------------------------------------
module tb_nibble_serial_sub_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  nibble_serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;

  vec_t vecs [7];

  // Reference: plain integer subtraction, unsigned for the borrow and
  // signed for the overflow range test.
  function automatic res_t refModel(input logic [15:0] a, input logic [15:0] b,
                                    input logic bin);
    res_t r;
    int   u;
    int   s;
    u      = int'(a) - int'(b) - int'(bin);
    s      = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.diff = u[15:0];
    r.bout = (u < 0);
    r.ovf  = (s > 32767) || (s < -32768);
    r.zero = (r.diff == 16'h0000);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!bus.idle && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.idle) checkOutput("idle_timeout", {31'h0, bus.idle}, 32'h1);
  endtask

  // Runs one operation from start to DONE, checking the per-cycle nibble
  // build-up of diff, the NIB-cycle latency and the final flags.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic bin, input logic [15:0] ediff,
                               input logic ebout, input logic eovf,
                               input logic ezero, input bit hold_start);
    int          u;
    logic [31:0] mask;
    waitIdle();
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
    bus.a   = 16'($urandom);
    bus.b   = 16'($urandom);
    bus.bin = 1'($urandom);
    checkOutput("busy_after_start", {31'h0, bus.busy}, 32'h1);
    checkOutput("diff_cleared", {16'h0, bus.diff}, 32'h0);
    u = int'(a) - int'(b) - int'(bin);
    for (int k = 1; k <= NIB; k++) begin
      @(posedge clk); #1;
      mask = (32'h1 << (4 * k)) - 32'h1;
      checkOutput("diff_partial", {16'h0, bus.diff}, 32'(u) & mask);
      if (k < NIB) checkOutput("busy_in_run", {31'h0, bus.busy}, 32'h1);
    end
    checkOutput("done_latency", {31'h0, bus.done}, 32'h1);
    checkOutput("diff", {16'h0, bus.diff}, {16'h0, ediff});
    checkOutput("bout", {31'h0, bus.bout}, {31'h0, ebout});
    checkOutput("ovf",  {31'h0, bus.ovf},  {31'h0, eovf});
    checkOutput("zero", {31'h0, bus.zero}, {31'h0, ezero});
    bus.start = 1'b0;
  endtask

  task automatic ackPulse();
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    checkOutput("idle_after_ack", {31'h0, bus.idle}, 32'h1);
    checkOutput("done_cleared", {31'h0, bus.done}, 32'h0);
  endtask

  initial begin
    res_t        m;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    vecs[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.ack   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst_n     = 1'b0;
    #12;
    checkOutput("rst_idle", {31'h0, bus.idle}, 32'h1);
    checkOutput("rst_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("rst_done", {31'h0, bus.done}, 32'h0);
    checkOutput("rst_diff", {16'h0, bus.diff}, 32'h0);
    checkOutput("rst_bout", {31'h0, bus.bout}, 32'h0);
    checkOutput("rst_ovf",  {31'h0, bus.ovf},  32'h0);
    checkOutput("rst_zero", {31'h0, bus.zero}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff,
                    vecs[i].bout, vecs[i].ovf, vecs[i].zero, 1'b0);
      ackPulse();
    end

    $display("[TB] start held through RUN");
    applyStimulus(16'h4321, 16'h1234, 1'b0, 16'h30ED, 1'b0, 1'b0, 1'b0, 1'b1);
    ackPulse();
    @(posedge clk); #1;
    checkOutput("no_second_op", {31'h0, bus.idle}, 32'h1);

    $display("[TB] done held without ack");
    applyStimulus(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("done_held", {31'h0, bus.done}, 32'h1);
      checkOutput("diff_stable", {16'h0, bus.diff}, 32'h00FE);
    end
    ackPulse();

    $display("[TB] start and ack together in DONE");
    applyStimulus(16'h0003, 16'h0007, 1'b0, 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    checkOutput("sa_idle", {31'h0, bus.idle}, 32'h1);
    checkOutput("sa_busy", {31'h0, bus.busy}, 32'h0);
    @(posedge clk); #1;
    checkOutput("sa_no_new_op", {31'h0, bus.idle}, 32'h1);
    checkOutput("sa_diff_kept", {16'h0, bus.diff}, 32'hFFFC);
    checkOutput("sa_bout_kept", {31'h0, bus.bout}, 32'h1);

    $display("[TB] randomized operations");
    for (int i = 0; i < 30; i++) begin
      ra   = 16'($urandom);
      rb   = (i % 5 == 0) ? ra : 16'($urandom);
      rbin = 1'($urandom);
      m    = refModel(ra, rb, rbin);
      applyStimulus(ra, rb, rbin, m.diff, m.bout, m.ovf, m.zero, 1'b0);
      ackPulse();
    end

    $display("[TB] reset during RUN");
    waitIdle();
    bus.a     = 16'h1234;
    bus.b     = 16'h1111;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_idle", {31'h0, bus.idle}, 32'h1);
    checkOutput("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("mid_rst_done", {31'h0, bus.done}, 32'h0);
    checkOutput("mid_rst_diff", {16'h0, bus.diff}, 32'h0);
    checkOutput("mid_rst_bout", {31'h0, bus.bout}, 32'h0);
    checkOutput("mid_rst_ovf",  {31'h0, bus.ovf},  32'h0);
    checkOutput("mid_rst_zero", {31'h0, bus.zero}, 32'h0);
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    ackPulse();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
